uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular byte FIFO.
// Frames are 1 start bit, 8 data bits sent LSB first, then STOP_BITS stop bits; queued bytes go out back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4386,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          serial_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [AW:0]     DEPTH     = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          push, pop, baud_end;

    assign tx_ready   = (level_q != DEPTH);
    assign push       = tx_valid && tx_ready;
    assign baud_end   = (baud_q == BAUD_LAST);
    assign serial_txd = txd_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign fifo_level = level_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                // bit_q doubles as the stop-bit counter here
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = START;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end
endmodule
